rx_time_parser: RTL and testbench

- Receive-side counterpart of the RTC-to-UART formatter: consumes ASCII bytes from the UART Rx core and parses a time-set command.
- Command format: "T" or "t", then 13 ASCII digits YYMMDDWHHMMSS, then CR or LF.
- On a valid, range-checked command, issues one BCD write to the RTC write path, holding off while the RTC is busy.
- Malformed or stalled commands are rejected with an error pulse.

---
 rtl/rx_time_parser.sv | 195 +++++++++++++++++++
 tb/tb_rx_time_parser.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_time_parser.sv
// Parses "T"/"t" + YYMMDDWHHMMSS + CR/LF from the UART Rx byte stream into BCD time registers.
// Latency: setStrobe two clocks after the terminator is sampled when rtcBusy is low; errStrobe one clock after the rejecting event.
// Backpressure: no Rx flow control; bytes arriving while parseBusy is high are dropped, and ISSUE stalls while rtcBusy is high.
module rx_time_parser #(
    parameter int TIMEOUT = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rxData,
    input  logic       rxValid,
    input  logic       rtcBusy,
    output logic       setStrobe,
    output logic       errStrobe,
    output logic       parseBusy,
    output logic [7:0] secData,
    output logic [7:0] minData,
    output logic [7:0] hrsData,
    output logic [7:0] dateData,
    output logic [7:0] monData,
    output logic [7:0] yrData,
    output logic [7:0] dayData
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);
    localparam int             NDIG     = 13;

    typedef enum logic [2:0] {
        IDLE,
        DIGITS,
        WAIT_TERM,
        CHECK,
        ISSUE,
        DISCARD
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [CW-1:0]   tmo_q;
    logic [3:0]      dig_q [NDIG];

    logic            set_q;
    logic            err_q;
    logic            busy_q;
    logic [7:0]      sec_q, min_q, hrs_q, date_q, mon_q, yr_q, day_q;

    logic            is_cmd;
    logic            is_digit;
    logic            is_term;
    logic            range_ok;

    // Byte classification of the current Rx byte.
    always_comb begin
        is_cmd   = (rxData == 8'h54) || (rxData == 8'h74);
        is_digit = (rxData >= 8'h30) && (rxData <= 8'h39);
        is_term  = (rxData == 8'h0D) || (rxData == 8'h0A);
    end

    // Range check of the buffered fields; buffer order is Y Y M M D D W H H M M S S.
    // Every stored nibble is already 0-9, so only field limits need testing.
    always_comb begin
        range_ok = 1'b1;
        // month 01-12
        if (!(((dig_q[2] == 4'd0) && (dig_q[3] != 4'd0)) ||
              ((dig_q[2] == 4'd1) && (dig_q[3] <= 4'd2))))
            range_ok = 1'b0;
        // date 01-31
        if (!(((dig_q[4] == 4'd0) && (dig_q[5] != 4'd0)) ||
              (dig_q[4] == 4'd1) || (dig_q[4] == 4'd2) ||
              ((dig_q[4] == 4'd3) && (dig_q[5] <= 4'd1))))
            range_ok = 1'b0;
        // day of week 1-7
        if ((dig_q[6] == 4'd0) || (dig_q[6] > 4'd7))
            range_ok = 1'b0;
        // hours 00-23
        if (!((dig_q[7] <= 4'd1) || ((dig_q[7] == 4'd2) && (dig_q[8] <= 4'd3))))
            range_ok = 1'b0;
        // minutes and seconds 00-59
        if ((dig_q[9] > 4'd5) || (dig_q[11] > 4'd5))
            range_ok = 1'b0;
    end

    // Parser FSM: state, digit buffer, inter-byte timeout, registered strobes and time registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            tmo_q   <= '0;
            for (int i = 0; i < NDIG; i++) dig_q[i] <= 4'd0;
            set_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            hrs_q   <= 8'h00;
            yr_q    <= 8'h00;
            date_q  <= 8'h01;
            mon_q   <= 8'h01;
            day_q   <= 8'h01;
        end else begin
            set_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (rxValid && is_cmd) begin
                        state_q <= DIGITS;
                        cnt_q   <= 4'd0;
                    end
                end

                DIGITS, WAIT_TERM, DISCARD: begin
                    if (rxValid) begin
                        tmo_q <= '0;
                        if (state_q == DIGITS) begin
                            if (is_digit) begin
                                for (int i = 0; i < NDIG; i++)
                                    if (cnt_q == 4'(i)) dig_q[i] <= rxData[3:0];
                                cnt_q <= cnt_q + 4'd1;
                                if (cnt_q == 4'(NDIG - 1)) state_q <= WAIT_TERM;
                            end else if (is_term) begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                state_q <= DISCARD;
                            end
                        end else if (state_q == WAIT_TERM) begin
                            if (is_term) begin
                                state_q <= CHECK;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= DISCARD;
                            end
                        end else if (is_term) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        // Stalled command: abandon it.
                        tmo_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + CW'(1);
                    end
                end

                CHECK: begin
                    tmo_q <= '0;
                    if (range_ok) begin
                        state_q <= ISSUE;
                    end else begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                ISSUE: begin
                    tmo_q <= '0;
                    if (!rtcBusy) begin
                        yr_q    <= {dig_q[0],  dig_q[1]};
                        mon_q   <= {dig_q[2],  dig_q[3]};
                        date_q  <= {dig_q[4],  dig_q[5]};
                        day_q   <= {4'd0,      dig_q[6]};
                        hrs_q   <= {dig_q[7],  dig_q[8]};
                        min_q   <= {dig_q[9],  dig_q[10]};
                        sec_q   <= {dig_q[11], dig_q[12]};
                        set_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    tmo_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign setStrobe = set_q;
    assign errStrobe = err_q;
    assign parseBusy = busy_q;
    assign secData   = sec_q;
    assign minData   = min_q;
    assign hrsData   = hrs_q;
    assign dateData  = date_q;
    assign monData   = mon_q;
    assign yrData    = yr_q;
    assign dayData   = day_q;

endmodule

// File: tb/tb_rx_time_parser.sv
// Scoreboard bench for rx_time_parser: directed commands push expected strobes, a monitor pops and compares.
// Data word order throughout is {yr, mon, date, day, hrs, min, sec}.
module tb_rx_time_parser;

    logic       clk;
    logic       rst;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rtcBusy;
    logic       setStrobe;
    logic       errStrobe;
    logic       parseBusy;
    logic [7:0] secData, minData, hrsData, dateData, monData, yrData, dayData;

    rx_time_parser #(.TIMEOUT(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .rtcBusy   (rtcBusy),
        .setStrobe (setStrobe),
        .errStrobe (errStrobe),
        .parseBusy (parseBusy),
        .secData   (secData),
        .minData   (minData),
        .hrsData   (hrsData),
        .dateData  (dateData),
        .monData   (monData),
        .yrData    (yrData),
        .dayData   (dayData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_set;
        logic [55:0] data;
    } exp_t;

    localparam logic [55:0] RESET_DATA = 56'h00_01_01_01_00_00_00;
    localparam logic [7:0]  CR = 8'h0D;
    localparam logic [7:0]  LF = 8'h0A;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [55:0] exp_regs;
    int          n_checks = 0;
    int          n_pass   = 0;

    wire [55:0] dut_data = {yrData, monData, dateData, dayData, hrsData, minData, secData};

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxData  = b;
        rxValid = 1'b1;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
        rxData  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            idle(1);
        end
    endtask

    task automatic send_cmd(input string body, input logic [7:0] term);
        send_str(body);
        send_byte(term);
        idle(4);
    endtask

    task automatic expect_set(input logic [55:0] d);
        exp_t e;
        e.is_set = 1'b1;
        e.data   = d;
        sb_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_set = 1'b0;
        e.data   = '0;
        sb_q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && (setStrobe || errStrobe)) begin
            check("strobe_exclusive", !(setStrobe && errStrobe), {62'd0, setStrobe, errStrobe}, 64'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", {setStrobe, errStrobe} == 2'b00, {62'd0, setStrobe, errStrobe}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("strobe_kind", setStrobe == mon_e.is_set, 64'(setStrobe), 64'(mon_e.is_set));
                if (mon_e.is_set) begin
                    check("set_data", dut_data == mon_e.data, 64'(dut_data), 64'(mon_e.data));
                    exp_regs = mon_e.data;
                end else begin
                    check("err_data_held", dut_data == exp_regs, 64'(dut_data), 64'(exp_regs));
                end
            end
        end
    end

    bit busy_ok;

    initial begin
        rst      = 1'b0;
        rxData   = 8'h00;
        rxValid  = 1'b0;
        rtcBusy  = 1'b0;
        exp_regs = RESET_DATA;
        idle(3);
        check("reset_data", dut_data == RESET_DATA, 64'(dut_data), 64'(RESET_DATA));
        check("reset_strobes", {setStrobe, errStrobe, parseBusy} == 3'b000,
              {61'd0, setStrobe, errStrobe, parseBusy}, 64'd0);
        rst = 1'b1;
        idle(2);

        // Valid command with exact latency probe.
        expect_set(56'h25_03_14_07_12_30_45);
        send_str("T2503147123045");
        send_byte(CR);
        check("latency_busy", parseBusy == 1'b1, 64'(parseBusy), 64'd1);
        idle(1);
        check("latency_early", setStrobe == 1'b0, 64'(setStrobe), 64'd0);
        idle(1);
        check("latency_set", setStrobe == 1'b1, 64'(setStrobe), 64'd1);
        idle(3);

        // Range failures.
        expect_err(); send_cmd("T2513147123045", LF);
        expect_err(); send_cmd("T2503140123045", CR);
        expect_err(); send_cmd("T2503147243045", CR);
        expect_err(); send_cmd("T2503147123060", CR);

        // Format errors.
        expect_err(); send_cmd("T25X3147123045", CR);
        expect_err(); send_cmd("T250314712304", CR);
        expect_err(); send_cmd("T25031471230456", CR);

        // Leading garbage is ignored, following command accepted.
        send_cmd("ab", CR);
        expect_set(56'h99_12_31_05_23_59_59);
        send_cmd("t9912315235959", CR);

        // Busy hold: write stalls while rtcBusy is high, stray 'T' dropped.
        rtcBusy = 1'b1;
        send_str("T0001011000000");
        send_byte(CR);
        busy_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!parseBusy) busy_ok = 1'b0;
            if (i == 50) send_byte(8'h54);
            else idle(1);
        end
        check("busy_hold_parseBusy", busy_ok, 64'(busy_ok), 64'd1);
        check("busy_hold_no_set", sb_q.size() == 0, 64'(sb_q.size()), 64'd0);
        expect_set(56'h00_01_01_01_00_00_00);
        rtcBusy = 1'b0;
        idle(4);
        check("busy_release_set_seen", sb_q.size() == 0, 64'(sb_q.size()), 64'd0);
        check("busy_release_idle", parseBusy == 1'b0, 64'(parseBusy), 64'd0);

        // Timeout after a partial command, then a full command is accepted.
        expect_err();
        send_str("T25");
        idle(12);
        check("timeout_not_early", sb_q.size() == 1, 64'(sb_q.size()), 64'd1);
        idle(13);
        check("timeout_err_seen", sb_q.size() == 0, 64'(sb_q.size()), 64'd0);
        expect_set(56'h20_01_01_02_08_00_00);
        send_cmd("T2001012080000", CR);

        // Reset mid-command: no strobe, rest of command ignored, data at reset values.
        send_str("T250314");
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        exp_regs = RESET_DATA;
        check("midreset_data", dut_data == RESET_DATA, 64'(dut_data), 64'(RESET_DATA));
        send_cmd("7123045", CR);
        check("midreset_ignored", dut_data == RESET_DATA, 64'(dut_data), 64'(RESET_DATA));

        idle(5);
        check("scoreboard_empty", sb_q.size() == 0, 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
